// File: rtl/rr_arbiter_n.sv
// ============================================================================
// Module      : rr_arbiter_n
// Description : Round-robin arbiter over 2**N requesters with hold-until-release
//               grants, optional hold-time limit and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_n #(
  parameter int N        = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [(1<<N)-1:0]   req,
  input  logic                done,
  output logic [(1<<N)-1:0]   gnt,
  output logic [N-1:0]        gnt_idx,
  output logic                gnt_valid,
  output logic                timeout
);

  localparam int R  = 1 << N;
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [N-1:0]    ptr, ptr_nx;
  logic [CW-1:0]   hold_cnt, hold_cnt_nx;
  logic [N-1:0]    gnt_idx_nx;
  logic            gnt_valid_nx;
  logic            timeout_nx;
  logic [R-1:0]    gnt_nx;

  logic [R-1:0]    arb_req;
  logic [N-1:0]    start;
  logic [N-1:0]    cand;
  logic [N-1:0]    sel;
  logic            found;
  logic            limit_hit;
  logic            release_ev;

  // Release detection and arbitration; on a release the search restarts just
  // past the grantee and the grantee itself is excluded for this one decision.
  always_comb begin
    arb_req    = req;
    start      = ptr;
    limit_hit  = 1'b0;
    release_ev = 1'b0;
    if (state == BUSY) begin
      limit_hit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
      release_ev = done || !req[gnt_idx] || limit_hit;
      if (release_ev) begin
        start            = gnt_idx + 1'b1;
        arb_req[gnt_idx] = 1'b0;
      end
    end
    found = 1'b0;
    sel   = start;
    cand  = start;
    for (int i = 0; i < R; i++) begin
      cand = start + N'(i);
      if (!found && arb_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    hold_cnt_nx  = hold_cnt;
    gnt_idx_nx   = gnt_idx;
    gnt_valid_nx = gnt_valid;
    timeout_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nx     = BUSY;
          gnt_idx_nx   = sel;
          gnt_valid_nx = 1'b1;
          hold_cnt_nx  = '0;
        end
      end
      BUSY: begin
        if (release_ev) begin
          ptr_nx     = gnt_idx + 1'b1;
          // Pulse only when the limit alone forced the release.
          timeout_nx = limit_hit && !done && req[gnt_idx];
          if (found) begin
            gnt_idx_nx  = sel;
            hold_cnt_nx = '0;
          end else begin
            state_nx     = IDLE;
            gnt_valid_nx = 1'b0;
          end
        end else begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    gnt_nx = '0;
    if (gnt_valid_nx) gnt_nx[gnt_idx_nx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_cnt_nx;
      gnt       <= gnt_nx;
      gnt_idx   <= gnt_idx_nx;
      gnt_valid <= gnt_valid_nx;
      timeout   <= timeout_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
// ============================================================================
// Module      : tb_rr_arbiter_n
// Description : Self-checking bench for rr_arbiter_n against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_n;

  localparam int N        = 2;
  localparam int R        = 1 << N;
  localparam int MAX_HOLD = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [R-1:0] req;
  logic         done;
  logic [R-1:0] gnt;
  logic [N-1:0] gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: age counts granted cycles including the current one.
  bit m_valid, m_tmo;
  int m_idx, m_ptr, m_age;
  bit n_valid, n_tmo;
  int n_idx, n_ptr, n_age;

  rr_arbiter_n #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_tmo = 0; m_idx = 0; m_ptr = 0; m_age = 0;
  endtask

  // Next-state of the model from the current inputs (called just before an edge).
  task automatic model_next();
    int  base, excl, c;
    bit  lim, rel, hit;
    n_valid = m_valid; n_idx = m_idx; n_ptr = m_ptr; n_age = m_age; n_tmo = 0;
    base = m_ptr; excl = -1; rel = 0;
    if (m_valid) begin
      lim = (MAX_HOLD != 0) && (m_age == MAX_HOLD);
      rel = done || !req[m_idx] || lim;
      if (!rel) n_age = m_age + 1;
      else begin
        n_ptr = (m_idx + 1) % R;
        base  = n_ptr;
        excl  = m_idx;
        n_tmo = lim && !done && req[m_idx];
      end
    end
    if (!m_valid || rel) begin
      hit = 0;
      for (int k = 0; k < R; k++) begin
        c = (base + k) % R;
        if (!hit && c != excl && req[c]) begin
          hit = 1; n_idx = c;
        end
      end
      n_valid = hit;
      if (hit) n_age = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [R-1:0] eg;
    eg = '0;
    if (m_valid) eg[m_idx] = 1'b1;
    chk({tag, ".valid"}, {31'd0, gnt_valid}, {31'd0, m_valid});
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    chk({tag, ".idx"}, 32'(gnt_idx), 32'(m_idx));
    chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, m_tmo});
  endtask

  task automatic step(input string tag);
    model_next();
    @(posedge clk);
    #1;
    m_valid = n_valid; m_idx = n_idx; m_ptr = n_ptr; m_age = n_age; m_tmo = n_tmo;
    check_outputs(tag);
  endtask

  // Asserts reset between edges and checks the outputs clear without a clock.
  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    req  = '0;
    done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();
    #2;
    check_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester after reset.
    req = 4'b0100;
    step("single");
    chk("single_idx2", 32'(gnt_idx), 32'd2);

    // All requesting, done every second cycle: 0,1,2,3,0 back-to-back.
    apply_reset("rst_rr");
    req = 4'b1111;
    step("rr_first");
    for (int g = 1; g <= 4; g++) begin
      done = 1'b1;
      step("rr_rel");
      chk("rr_order", 32'(gnt_idx), 32'(g % R));
      done = 1'b0;
      step("rr_hold");
    end

    // Lone requester 3 releases: one idle cycle, then re-granted; ptr wraps.
    apply_reset("rst_wrap");
    req = 4'b1000;
    step("wrap_grant");
    done = 1'b1;
    step("wrap_rel");
    chk("wrap_idle", {31'd0, gnt_valid}, 32'd0);
    done = 1'b0;
    step("wrap_regrant");
    chk("wrap_gnt", 32'(gnt), 32'b1000);

    // Hold limit revokes idx 0 after MAX_HOLD cycles.
    apply_reset("rst_tmo");
    req = 4'b0011;
    for (int c = 0; c < MAX_HOLD; c++) step("tmo_hold");
    step("tmo_fire");
    chk("tmo_pulse", {31'd0, timeout}, 32'd1);
    chk("tmo_next", 32'(gnt), 32'b0010);
    step("tmo_after");

    // done coincides with the hold limit: no timeout.
    apply_reset("rst_both");
    req = 4'b0011;
    for (int c = 0; c < MAX_HOLD; c++) step("both_hold");
    done = 1'b1;
    step("both_rel");
    chk("both_notmo", {31'd0, timeout}, 32'd0);
    chk("both_next", 32'(gnt_idx), 32'd1);
    done = 1'b0;

    // Reset mid-grant, between edges.
    step("mid_busy");
    apply_reset("rst_mid");
    req = 4'b1111;
    step("post_rst");
    chk("post_rst_gnt", 32'(gnt), 32'b0001);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) != 0) req = R'($urandom_range(0, R - 1) == 0 ? 0 : $urandom);
      done = ($urandom_range(0, 3) == 0);
      step("rand");
      chk("rand_onehot", {31'd0, ($countones(gnt) <= 1)}, 32'd1);
      if (c % 150 == 149) apply_reset("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_arbiter_n.md
RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 Parameter N, default 2: requester index width; the number of requesters R SHALL be 2**N.
REQ-002 Parameter MAX_HOLD, default 16: maximum grant duration in cycles; a value of 0 SHALL disable the hold limit.
REQ-003 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1: the reset; it SHALL be asynchronous and active-low.
REQ-005 Port req  input  R: request vector, one bit per requester, level-sensitive.
REQ-006 Port done  input  1: the current grantee releases the resource in this cycle.
REQ-007 Port gnt  output  R: one-hot grant vector, registered.
REQ-008 Port gnt_idx  output  N: binary index of the grantee, registered; gnt SHALL equal the N-to-R decode of gnt_idx whenever gnt_valid=1.
REQ-009 Port gnt_valid  output  1: a grant is active, registered.
REQ-010 Port timeout  output  1: single-cycle pulse, registered; asserted when a grant is revoked because it reached MAX_HOLD.

Function
REQ-011 The block SHALL use a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-012 The block SHALL keep a priority pointer ptr[N-1:0]; the search order SHALL be ptr, ptr+1, ..., ptr-1, with indices taken modulo R.
REQ-013 IDLE, req!=0: the block SHALL select the first set req bit in search order, go to BUSY, and drive gnt, gnt_idx and gnt_valid=1 from the next edge (1-cycle latency).
REQ-014 IDLE, req==0: outputs SHALL stay gnt=0, gnt_valid=0, with gnt_idx holding its last value.
REQ-015 BUSY: the grant SHALL be held unchanged regardless of other req bits until a release event occurs.
REQ-016 The release events SHALL be: done=1; req[gnt_idx]=0 (requester drops); or hold counter = MAX_HOLD-1 when MAX_HOLD!=0.
REQ-017 On a release, ptr SHALL become gnt_idx+1 mod R (wrap from R-1 to 0).
REQ-018 On a release, arbitration SHALL run in the same cycle using the updated ptr and the current req with the releasing bit masked out.
REQ-019 If that arbitration selects a requester, the new grant SHALL appear on the next edge with no idle cycle (back-to-back).
REQ-020 If that arbitration selects no requester, the block SHALL go to IDLE and drive gnt_valid=0 on the next edge.
REQ-021 The releasing requester SHALL NOT be re-granted on the cycle immediately after its own release, even if it is the only requester.
REQ-022 It SHALL become eligible again one cycle later.
REQ-023 Hold counter: it SHALL be cleared on every new grant and increment each BUSY cycle.
REQ-024 timeout SHALL be 1 for exactly one cycle, coincident with the first cycle the revoked grant is deasserted, only when the hold limit caused the release.
REQ-025 If done=1 and the hold limit are reached in the same cycle, the release SHALL be treated as done and timeout SHALL stay 0.
REQ-026 gnt SHALL never have more than one bit set; gnt SHALL be 0 whenever gnt_valid=0.
REQ-027 Fairness: with all R requesters continuously asserted, each SHALL receive exactly one grant in every R consecutive grants.
REQ-028 done=1 while in IDLE SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, ptr=0, counter=0, gnt=0, gnt_idx=0, gnt_valid=0 and timeout=0.
REQ-030 Reset asserted mid-grant SHALL abort the grant with no timeout pulse.
REQ-031 After rst_n rises, the first arbitration SHALL occur on the first rising clk edge with rst_n=1.

Verification
REQ-032 N=2, reset release, req=0100 -> next cycle gnt=0100, gnt_idx=2, gnt_valid=1.
REQ-033 req=1111 held, done pulsed every 2nd cycle -> grant sequence 0,1,2,3,0 with no idle cycles between grants.
REQ-034 Grant idx=3, done=1, req=1000 only -> one cycle gnt_valid=0, then gnt=1000 again; ptr wraps to 0.
REQ-035 MAX_HOLD=4, req=0011 held, done=0 -> idx 0 granted for 4 cycles, then timeout=1 for one cycle with gnt=0010.
REQ-036 Same cycle: done=1 and hold limit reached -> timeout stays 0 and the next grant follows normally.
REQ-037 rst_n pulled low mid-BUSY between clock edges -> gnt=0 and gnt_valid=0 immediately; after release, req=1111 -> gnt=0001.
